// File: rtl/spi_mem_slave.sv
// Bit-serial slave exposing a 2**ADDR_W x DATA_W register memory to an external master.
// Optional `SPI_MEM_BURST_EN: consecutive words with auto-incrementing address while cs_n stays low.
module spi_mem_slave #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16,
    parameter int TURN   = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_n,
    input  logic din,
    output logic dout,
    output logic dout_oe,
    output logic wr_done
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CMD, S_TURN, S_DATA, S_HOLD} state_t;

    state_t              state, state_d;
    logic [15:0]         cnt, cnt_d;
    logic                armed, armed_d;
    logic [ADDR_W-1:0]   addr, addr_d;
    logic                rw, rw_d;
    logic [DATA_W-2:0]   wsh, wsh_d;
    logic [DATA_W-1:0]   rsh, rsh_d;
    logic                dout_d, oe_d, wr_done_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rdata;
    logic [DATA_W-1:0]   wdata;
    logic [ADDR_W-1:0]   mem_raddr;
    logic                mem_re, mem_we, last;

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        armed_d   = armed;
        addr_d    = addr;
        rw_d      = rw;
        wsh_d     = wsh;
        rsh_d     = rsh;
        dout_d    = dout;
        oe_d      = dout_oe;
        wr_done_d = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_raddr = addr;
        wdata     = {wsh, din};
        last      = (cnt == 16'(DATA_W - 1));

        if (cs_n) begin
            // Frame end or abort: a partially shifted write word is simply dropped.
            state_d = S_IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
            dout_d  = 1'b0;
            armed_d = 1'b1;
        end else if (armed) begin
            case (state)
                S_IDLE, S_ADDR: begin
                    addr_d = ADDR_W'({addr, din});
                    if (cnt == 16'(ADDR_W - 1)) begin
                        state_d = S_CMD;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_ADDR;
                        cnt_d   = cnt + 16'd1;
                    end
                end
                S_CMD: begin
                    rw_d    = din;
                    mem_re  = 1'b1;
                    state_d = S_TURN;
                    cnt_d   = '0;
                end
                S_TURN: begin
                    if (cnt == 16'(TURN - 1)) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        if (!rw) begin
                            dout_d = rdata[DATA_W-1];
                            rsh_d  = rdata << 1;
                            oe_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (rw) begin
                        wsh_d = wdata[DATA_W-2:0];
                        if (last) begin
                            mem_we    = 1'b1;
                            wr_done_d = 1'b1;
                        end
                    end else if (!last) begin
                        dout_d = rsh[DATA_W-1];
                        rsh_d  = rsh << 1;
                    end
`ifdef SPI_MEM_BURST_EN
                    // Prefetch the next read word early so its MSB is ready at the word boundary.
                    if (!rw && cnt == 16'd0) begin
                        mem_re    = 1'b1;
                        mem_raddr = addr + 1'b1;
                        addr_d    = addr + 1'b1;
                    end
                    if (last) begin
                        cnt_d = '0;
                        if (rw) begin
                            addr_d = addr + 1'b1;
                        end else begin
                            dout_d = rdata[DATA_W-1];
                            rsh_d  = rdata << 1;
                        end
                    end else begin
                        cnt_d = cnt + 16'd1;
                    end
`else
                    if (last) begin
                        state_d = S_HOLD;
                        oe_d    = 1'b0;
                        dout_d  = 1'b0;
                    end else begin
                        cnt_d = cnt + 16'd1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            armed   <= 1'b0;
            addr    <= '0;
            rw      <= 1'b0;
            dout    <= 1'b0;
            dout_oe <= 1'b0;
            wr_done <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            armed   <= armed_d;
            addr    <= addr_d;
            rw      <= rw_d;
            dout    <= dout_d;
            dout_oe <= oe_d;
            wr_done <= wr_done_d;
        end
    end

    always_ff @(posedge clk) begin
        wsh <= wsh_d;
        rsh <= rsh_d;
        if (mem_re) rdata <= mem[mem_raddr];
        if (mem_we) mem[addr] <= wdata;
    end

endmodule

// File: tb/tb_spi_mem_slave.sv
// Scoreboard bench for spi_mem_slave at default parameters (H = 8).
module tb_spi_mem_slave;
    localparam int H  = 8;
    localparam int DW = 16;
`ifdef SPI_MEM_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, cs_n, din;
    logic dout, dout_oe, wr_done;

    int n_chk  = 0;
    int n_pass = 0;
    logic [15:0] model [32];
    logic [15:0] exp_q [$];

    spi_mem_slave dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .din(din),
        .dout(dout), .dout_oe(dout_oe), .wr_done(wr_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One frame of ncyc cs_n-low edges, followed by the cs_n-high edge.
    task automatic frame(input logic [4:0] a, input logic rw, input logic [15:0] wd, input int ncyc);
        logic [15:0] got;
        logic [4:0]  idx;
        int nb;
        int nwords;
        bit exp_oe, exp_wd;
        got = '0;
        nb  = 0;
        if (!rw && ncyc >= H + DW) begin
            nwords = BURST ? (ncyc - H) / DW : 1;
            for (int i = 0; i < nwords; i++) begin
                idx = a + 5'(i);
                exp_q.push_back(model[idx]);
            end
        end
        for (int k = 0; k <= ncyc; k++) begin
            @(negedge clk);
            exp_oe = !rw && k >= H && (BURST || k < H + DW);
            exp_wd = rw && k > H && ((k - H) % DW == 0) && (BURST || k == H + DW);
            chk($sformatf("oe a%0d k%0d", a, k), int'(dout_oe), int'(exp_oe));
            chk($sformatf("wr_done a%0d k%0d", a, k), int'(wr_done), int'(exp_wd));
            if (dout_oe) begin
                got = {got[14:0], dout};
                nb++;
                if (nb % DW == 0) begin
                    if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
                    else chk($sformatf("rd_word a%0d", a), int'(got), int'(exp_q.pop_front()));
                end
            end
            if (k < ncyc) begin
                cs_n = 1'b0;
                if (k < 5)       din = a[4 - k];
                else if (k == 5) din = rw;
                else if (k < H)  din = 1'($urandom);
                else if (rw && (BURST || k < H + DW)) din = wd[15 - ((k - H) % DW)];
                else             din = 1'($urandom);
                if (rw && k >= H && ((k - H) % DW == DW - 1) && (BURST || k == H + DW - 1)) begin
                    idx = a + 5'((k - H) / DW);
                    model[idx] = wd;
                end
            end else begin
                cs_n = 1'b1;
            end
        end
        @(negedge clk);
        chk("oe_after_frame", int'(dout_oe), 0);
        chk("wr_done_after_frame", int'(wr_done), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        cs_n  = 1'b1;
        din   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dout", int'(dout), 0);
        chk("rst_oe", int'(dout_oe), 0);
        chk("rst_wr_done", int'(wr_done), 0);
        rst_n = 1'b1;

        frame(5'h13, 1'b1, 16'hA5C3, 24);
        frame(5'h13, 1'b0, 16'h0000, 24);

        // Reset at k = 10 of a read of 0x13.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            cs_n = 1'b0;
            if (k < 5)       din = 5'h13 >> (4 - k);
            else             din = 1'b0;
        end
        @(negedge clk);
        chk("pre_rst_oe", int'(dout_oe), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", int'(dout), 0);
        chk("mid_rst_oe", int'(dout_oe), 0);
        @(negedge clk);
        cs_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        frame(5'h13, 1'b0, 16'h0000, 24);

        // Aborted write leaves memory untouched.
        frame(5'h02, 1'b1, 16'h1234, 24);
        frame(5'h02, 1'b1, 16'hFFFF, 15);
        frame(5'h02, 1'b0, 16'h0000, 24);

        // Address extremes.
        frame(5'h00, 1'b1, 16'hFFFF, 24);
        frame(5'h1F, 1'b1, 16'h0001, 24);
        frame(5'h00, 1'b0, 16'h0000, 24);
        frame(5'h1F, 1'b0, 16'h0000, 24);

`ifdef SPI_MEM_BURST_EN
        frame(5'h1F, 1'b1, 16'hBEEF, 24);
        frame(5'h00, 1'b1, 16'h0F0F, 24);
        frame(5'h1F, 1'b0, 16'h0000, H + 32);
`else
        // Long frames: HOLD after one word, din ignored.
        frame(5'h13, 1'b0, 16'h0000, 40);
        frame(5'h07, 1'b1, 16'h5A5A, 40);
        frame(5'h07, 1'b0, 16'h0000, 24);
`endif

        chk("sb_leftover", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
